// File: rtl/arf_sched_pkg.sv
// Shared types and constants for the ARF output-stage MAC scheduler:
// FSM states, the fixed multiply order, and coefficient index names.
package arf_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  localparam int NUM_STEPS = 10;

  // Coefficient / sample slot for each physical input (slot k uses C[k]).
  localparam int C_IN1  = 0;
  localparam int C_IN2  = 1;
  localparam int C_IN3  = 2;
  localparam int C_IN4  = 3;
  localparam int C_IN5  = 4;
  localparam int C_IN6  = 5;
  localparam int C_IN7  = 6;
  localparam int C_IN8  = 7;
  localparam int C_IN13 = 8;
  localparam int C_IN14 = 9;

  // All out_27 terms first, then all out_28 terms, so out_27 settles early.
  function automatic int step_sample(input int step);
    case (step)
      0:       return C_IN1;
      1:       return C_IN2;
      2:       return C_IN3;
      3:       return C_IN4;
      4:       return C_IN13;
      5:       return C_IN5;
      6:       return C_IN6;
      7:       return C_IN7;
      8:       return C_IN8;
      9:       return C_IN14;
      default: return C_IN1;
    endcase
  endfunction

  function automatic logic feeds_acc28(input int idx);
    return idx inside {C_IN5, C_IN6, C_IN7, C_IN8, C_IN14};
  endfunction

  function automatic int unity_coef(input int frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/arf_mac_sched_if.sv
// Sample, result and coefficient-config bus between the sample source,
// the ARF MAC scheduler and the downstream error-statistics stage.
interface arf_mac_sched_if
  import arf_sched_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_STEPS*DW-1:0] in_x;
  logic                    out_valid;
  logic                    out_ready;
  logic [DW-1:0]           out_27;
  logic [DW-1:0]           out_28;
  logic                    cfg_we;
  logic [3:0]              cfg_addr;
  logic [CW-1:0]           cfg_data;
  logic                    cfg_err;
  logic                    busy;

  modport master (
    output in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_27, out_28, cfg_err, busy
  );

  modport slave (
    input  in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_27, out_28, cfg_err, busy
  );

endinterface

// File: rtl/arf_mac_unit.sv
// Single shared signed multiplier feeding two accumulators; the *_next
// outputs expose the value the accumulators take at the coming edge.
module arf_mac_unit
  import arf_sched_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 16,
  parameter int AW = DW + CW + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 sel28,
  input  logic signed [DW-1:0] sample,
  input  logic signed [CW-1:0] coef,
  output logic signed [AW-1:0] acc27_next,
  output logic signed [AW-1:0] acc28_next
);

  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    acc27_reg;
  logic signed [AW-1:0]    acc28_reg;

  assign prod     = sample * coef;
  assign prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};

  always_comb begin
    acc27_next = acc27_reg;
    acc28_next = acc28_reg;
    if (en && !sel28) acc27_next = acc27_reg + prod_ext;
    if (en && sel28)  acc28_next = acc28_reg + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc27_reg <= '0;
      acc28_reg <= '0;
    end else begin
      acc27_reg <= acc27_next;
      acc28_reg <= acc28_next;
    end
  end

endmodule

// File: rtl/arf_mac_sched.sv
// ARF output stage: one multiply per cycle, 10 steps per sample set.
// Build option ARF_SAT_EN: saturate results to DW bits instead of wrapping.
module arf_mac_sched
  import arf_sched_pkg::*;
#(
  parameter int DW        = 32,
  parameter int CW        = 16,
  parameter int COEF_FRAC = 8,
  parameter int AW        = DW + CW + 4
) (
  input logic            clk,
  input logic            rst,
  arf_mac_sched_if.slave bus
);

  localparam logic signed [CW-1:0] UNITY = CW'(unity_coef(COEF_FRAC));

  state_t               state_reg;
  logic [3:0]           step_reg;
  logic                 out_valid_reg;
  logic [DW-1:0]        out27_reg;
  logic [DW-1:0]        out28_reg;
  logic                 cfg_err_reg;
  logic signed [DW-1:0] sample_reg    [NUM_STEPS];
  logic signed [CW-1:0] coef_reg      [NUM_STEPS];
  logic signed [CW-1:0] work_coef_reg [NUM_STEPS];

  logic                 accept;
  logic                 cfg_ok;
  logic                 last_step;
  logic [3:0]           cur_idx;
  logic signed [AW-1:0] acc27_next;
  logic signed [AW-1:0] acc28_next;
  logic signed [AW-1:0] sh27;
  logic signed [AW-1:0] sh28;

  assign accept    = (state_reg == IDLE) && bus.in_valid;
  assign cfg_ok    = bus.cfg_we && (state_reg == IDLE) && (bus.cfg_addr <= 4'(NUM_STEPS - 1));
  assign last_step = (step_reg == 4'(NUM_STEPS - 1));
  assign cur_idx   = 4'(step_sample(int'(step_reg)));

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_27    = out27_reg;
  assign bus.out_28    = out28_reg;
  assign bus.cfg_err   = cfg_err_reg;

  arf_mac_unit #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .en         (state_reg == MAC),
    .sel28      (feeds_acc28(int'(cur_idx))),
    .sample     (sample_reg[cur_idx]),
    .coef       (work_coef_reg[cur_idx]),
    .acc27_next (acc27_next),
    .acc28_next (acc28_next)
  );

  // The last step's product is folded in via acc*_next so the result lands on that same edge.
  assign sh27 = acc27_next >>> COEF_FRAC;
  assign sh28 = acc28_next >>> COEF_FRAC;

  function automatic logic [DW-1:0] narrow(input logic signed [AW-1:0] v);
`ifdef ARF_SAT_EN
    logic signed [AW-1:0] sat_max;
    logic signed [AW-1:0] sat_min;
    sat_max = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    sat_min = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (v > sat_max) return sat_max[DW-1:0];
    if (v < sat_min) return sat_min[DW-1:0];
    return v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      out_valid_reg <= 1'b0;
      out27_reg     <= '0;
      out28_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            step_reg  <= '0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          if (last_step) begin
            out27_reg     <= narrow(sh27);
            out28_reg     <= narrow(sh28);
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            step_reg <= step_reg + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err_reg <= 1'b0;
    else     cfg_err_reg <= bus.cfg_we && !cfg_ok;
  end

  // Working copy of the coefficients is frozen at accept, so a write landing on the
  // accept edge only affects later sets.
  for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        sample_reg[gi]    <= '0;
        coef_reg[gi]      <= UNITY;
        work_coef_reg[gi] <= UNITY;
      end else begin
        if (accept) begin
          sample_reg[gi]    <= bus.in_x[gi*DW +: DW];
          work_coef_reg[gi] <= coef_reg[gi];
        end
        if (cfg_ok && (bus.cfg_addr == 4'(gi))) coef_reg[gi] <= bus.cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_arf_mac_sched.sv
// Directed + random bench for arf_mac_sched with a reference-model scoreboard.
// Honours ARF_SAT_EN the same way the design does.
module tb_arf_mac_sched;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arf_mac_sched_if #(.DW(DW), .CW(CW)) bus ();

  arf_mac_sched #(.DW(DW), .CW(CW), .COEF_FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mc [NS];
  logic [63:0] exp_q [$];
  logic [31:0] smp [NS];
  logic [319:0] x;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] nar(input longint v);
`ifdef ARF_SAT_EN
    if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < -(64'sh8000_0000)) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  // out_27 terms: in_1..in_4 (slots 0-3), in_13 (slot 8); the rest go to out_28.
  function automatic logic [63:0] model(input logic [319:0] xin);
    longint a27 = 0;
    longint a28 = 0;
    longint p;
    for (int k = 0; k < NS; k++) begin
      p = longint'($signed(xin[k*32 +: 32])) * longint'($signed(mc[k]));
      if ((k >= 4 && k <= 7) || k == 9) a28 += p;
      else a27 += p;
    end
    return {nar(a27 >>> 8), nar(a28 >>> 8)};
  endfunction

  function automatic logic [319:0] pack_x(input logic [31:0] s [NS]);
    logic [319:0] r;
    for (int k = 0; k < NS; k++) r[k*32 +: 32] = s[k];
    return r;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < NS; k++) mc[k] = 16'd256;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    tick();
    bus.cfg_we = 1'b0;
    chk("cfg_err_idle", {63'd0, bus.cfg_err}, {63'd0, (a > 4'd9)});
    if (a <= 4'd9) mc[a] = d;
    $display("cfg write addr=%0d data=%0h err=%0b", a, d, bus.cfg_err);
  endtask

  // mode: 0 plain, 1 cfg write during MAC, 2 cfg write on the accept cycle, 3 reset at MAC step 5
  task automatic run_set(input logic [319:0] xin, input int mode, input int hold,
                         input logic [3:0] wa, input logic [15:0] wd);
    int edges;
    logic [63:0] e;
    chk("in_ready_before", {63'd0, bus.in_ready}, 64'd1);
    bus.in_x = xin;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(xin));
    if (mode == 2) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = wa; bus.cfg_data = wd;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b0;
    if (mode == 2) begin
      mc[wa] = wd;
      chk("cfg_err_accept", {63'd0, bus.cfg_err}, 64'd0);
    end
    chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    chk("in_ready_after_accept", {63'd0, bus.in_ready}, 64'd0);
    edges = 0;
    if (mode == 3) begin
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      void'(exp_q.pop_back());
      reset_model();
      $display("set abandoned by reset at MAC step 5");
      return;
    end
    if (mode == 1) begin
      tick(); tick();
      bus.cfg_we = 1'b1; bus.cfg_addr = wa; bus.cfg_data = wd;
      tick();
      bus.cfg_we = 1'b0;
      chk("cfg_err_mac", {63'd0, bus.cfg_err}, 64'd1);
      tick();
      chk("cfg_err_pulse_end", {63'd0, bus.cfg_err}, 64'd0);
      edges = 4;
    end
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    chk("latency", 64'(edges), 64'd10);
    e = exp_q.pop_front();
    chk("out_27", {32'd0, bus.out_27}, {32'd0, e[63:32]});
    chk("out_28", {32'd0, bus.out_28}, {32'd0, e[31:0]});
    $display("set x0=%0h out_27=%0h out_28=%0h exp=%0h/%0h lat=%0d",
             xin[31:0], bus.out_27, bus.out_28, e[63:32], e[31:0], edges);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_x = ~xin;
      tick();
      chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_out_27", {32'd0, bus.out_27}, {32'd0, e[63:32]});
      chk("hold_out_28", {32'd0, bus.out_28}, {32'd0, e[31:0]});
      chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("handshake_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("handshake_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("keep_out_27", {32'd0, bus.out_27}, {32'd0, e[63:32]});
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    reset_model();
    @(negedge clk);
    repeat (3) tick();
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_out_27", {32'd0, bus.out_27}, 64'd0);
    chk("reset_out_28", {32'd0, bus.out_28}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_cfg_err", {63'd0, bus.cfg_err}, 64'd0);
    rst = 1'b0;
    tick();
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Basic set with unity coefficients
    smp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd20, 32'd30, 32'd40, 32'd5, 32'hFFFF_FF9C};
    x = pack_x(smp);
    run_set(x, 0, 0, 4'd0, 16'd0);
    chk("basic_out_27", {32'd0, bus.out_27}, 64'd15);
    chk("basic_out_28", {32'd0, bus.out_28}, 64'd0);

    cfg_write(4'd0, 16'd768);
    run_set(x, 0, 0, 4'd0, 16'd0);
    run_set(x, 1, 0, 4'd1, 16'd999);
    run_set(x, 0, 0, 4'd0, 16'd0);
    run_set(x, 0, 20, 4'd0, 16'd0);
    cfg_write(4'd12, 16'd77);

    // Full-scale samples and coefficients
    for (int k = 0; k < NS; k++) cfg_write(4'(k), 16'h7FFF);
    for (int k = 0; k < NS; k++) smp[k] = 32'h7FFF_FFFF;
    run_set(pack_x(smp), 0, 0, 4'd0, 16'd0);
`ifdef ARF_SAT_EN
    chk("sat_out_27", {32'd0, bus.out_27}, 64'h7FFF_FFFF);
    chk("sat_out_28", {32'd0, bus.out_28}, 64'h7FFF_FFFF);
`endif

    cfg_write(4'd4, 16'hFF00);
    for (int k = 0; k < NS; k++) smp[k] = 32'd0;
    smp[4] = 32'd7;
    run_set(pack_x(smp), 0, 0, 4'd0, 16'd0);
    chk("neg_out_28", {32'd0, bus.out_28}, 64'hFFFF_FFF9);

    cfg_write(4'd0, 16'd1);
    for (int k = 0; k < NS; k++) smp[k] = 32'd0;
    smp[0] = 32'hFFFF_FFFF;
    run_set(pack_x(smp), 0, 0, 4'd0, 16'd0);
    chk("ashift_out_27", {32'd0, bus.out_27}, 64'hFFFF_FFFF);

    run_set(x, 3, 0, 4'd0, 16'd0);
    run_set(x, 0, 0, 4'd0, 16'd0);
    chk("post_rst_out_27", {32'd0, bus.out_27}, 64'd15);
    chk("post_rst_out_28", {32'd0, bus.out_28}, 64'd0);

    run_set(x, 2, 0, 4'd0, 16'd768);
    chk("accept_write_old_coef", {32'd0, bus.out_27}, 64'd15);
    run_set(x, 0, 0, 4'd0, 16'd0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write(4'($urandom_range(0, 15)), 16'($urandom));
      for (int k = 0; k < NS; k++) smp[k] = $urandom;
      run_set(pack_x(smp), 0, int'($urandom_range(0, 2)), 4'd0, 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
